// File: rtl/dwc_ddrphy_pmu_acsm_pkg.sv
// Shared types and constants for the ACSM command RAM read sequencer.
package dwc_ddrphy_pmu_acsm_pkg;

  localparam int ACSM_DATAWID = 72;
  localparam int ACSM_DEPTH   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } acsm_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int acsm_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dwc_ddrphy_pmu_acsm_seq_fifo.sv
// Two-entry FIFO of {last,data} words; flush empties it and overrides push/pop.
module dwc_ddrphy_pmu_acsm_seq_fifo #(
  parameter int WID = 73
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  logic [WID-1:0] push_data,
  output logic           valid,
  output logic           full,
  output logic [WID-1:0] head_data
);

  logic [WID-1:0] mem_q [2];
  logic [WID-1:0] mem_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           do_push_s, do_pop_s;

  assign valid     = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    do_pop_s  = pop && valid;
    do_push_s = push && (!full || do_pop_s);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dwc_ddrphy_pmu_acsm_seq.sv
// ACSM command RAM read sequencer: host write mux in idle, looped address
// streaming with one-cycle RAM latency absorbed by a 2-entry output FIFO.
module dwc_ddrphy_pmu_acsm_seq
  import dwc_ddrphy_pmu_acsm_pkg::*;
#(
  parameter  int DATAWID = ACSM_DATAWID,
  parameter  int DEPTH   = ACSM_DEPTH,
  parameter  int LOOPWID = 16,
  localparam int AW      = acsm_log2(DEPTH)
) (
  input  logic               DfiClk,
  input  logic               Reset_n,
  input  logic [AW-1:0]      cfg_start_addr,
  input  logic [AW-1:0]      cfg_stop_addr,
  input  logic [LOOPWID-1:0] cfg_loop_cnt,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  input  logic               host_wr,
  input  logic [AW-1:0]      host_addr,
  input  logic [DATAWID-1:0] host_wrdata,
  output logic               host_wr_err,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_ce,
  output logic               ram_wr,
  output logic [DATAWID-1:0] ram_wrdata,
  input  logic [DATAWID-1:0] ram_rddata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [DATAWID-1:0] cmd_data,
  output logic               cmd_last
);

  acsm_state_e        state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      start_q, start_d;
  logic [AW-1:0]      stop_q, stop_d;
  logic [LOOPWID-1:0] loops_q, loops_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               host_wr_err_q, host_wr_err_d;

  logic               fifo_valid_s, fifo_full_s, fifo_flush_s;
  logic [DATAWID:0]   fifo_head_s;
  logic [1:0]         occ_s;
  logic [2:0]         room_s;
  logic               pop_s, issue_s, last_issue_s;

  assign pop_s        = fifo_valid_s && cmd_ready;
  assign occ_s        = {fifo_full_s, fifo_valid_s && !fifo_full_s};
  // Words committed to the FIFO after this edge: held + returning - leaving.
  assign room_s       = ({1'b0, occ_s} + {2'b00, inflight_q}) - {2'b00, pop_s};
  assign last_issue_s = (rd_ptr_q == stop_q) && (loops_q == '0);
  assign fifo_flush_s = abort && (state_q != ST_IDLE);

  // RAM pin mux: host write in idle, read issue while running.
  always_comb begin
    ram_ce     = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = '0;
    ram_wrdata = '0;
    issue_s    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (host_wr) begin
        ram_ce     = 1'b1;
        ram_wr     = 1'b1;
        ram_addr   = host_addr;
        ram_wrdata = host_wrdata;
      end else begin
        ram_ce = 1'b0;
      end
    end else if ((state_q == ST_RUN) && !abort && (room_s < 3'd2)) begin
      issue_s  = 1'b1;
      ram_ce   = 1'b1;
      ram_addr = rd_ptr_q;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Sequencer next-state and registered status pulses.
  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    start_d         = start_q;
    stop_d          = stop_q;
    loops_d         = loops_q;
    done_d          = 1'b0;
    cfg_err_d       = 1'b0;
    host_wr_err_d   = host_wr && (state_q != ST_IDLE);
    inflight_d      = issue_s;
    inflight_last_d = issue_s && last_issue_s;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_start_addr <= cfg_stop_addr) begin
            rd_ptr_d = cfg_start_addr;
            start_d  = cfg_start_addr;
            stop_d   = cfg_stop_addr;
            loops_d  = cfg_loop_cnt;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (issue_s) begin
          if (rd_ptr_q != stop_q) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end else if (loops_q != '0) begin
            rd_ptr_d = start_q;
            loops_d  = loops_q - LOOPWID'(1);
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pop_s && fifo_head_s[DATAWID]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state registers.
  always_ff @(posedge DfiClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      start_q         <= '0;
      stop_q          <= '0;
      loops_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
      host_wr_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      start_q         <= start_d;
      stop_q          <= stop_d;
      loops_q         <= loops_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cfg_err_q       <= cfg_err_d;
      host_wr_err_q   <= host_wr_err_d;
    end
  end

  dwc_ddrphy_pmu_acsm_seq_fifo #(
    .WID (DATAWID + 1)
  ) u_fifo (
    .clk       (DfiClk),
    .rst_n     (Reset_n),
    .push      (inflight_q),
    .pop       (pop_s),
    .flush     (fifo_flush_s),
    .push_data ({inflight_last_q, ram_rddata}),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s),
    .head_data (fifo_head_s)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign host_wr_err = host_wr_err_q;
  assign cmd_valid   = fifo_valid_s;
  assign cmd_data    = fifo_head_s[DATAWID-1:0];
  assign cmd_last    = fifo_head_s[DATAWID];

endmodule

// File: tb/tb_dwc_ddrphy_pmu_acsm_seq.sv
// Scoreboard bench for the ACSM read sequencer with a behavioural 1-cycle RAM.
module tb_dwc_ddrphy_pmu_acsm_seq;

  localparam int DW = 72;
  localparam int AW = 10;
  typedef logic [DW:0] word_t;

  logic          DfiClk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [AW-1:0] cfg_start_addr = '0, cfg_stop_addr = '0;
  logic [15:0]   cfg_loop_cnt = '0;
  logic          start = 1'b0, abort = 1'b0, host_wr = 1'b0, cmd_ready = 1'b1;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wrdata = '0;
  logic          busy, done, cfg_err, host_wr_err, ram_ce, ram_wr, cmd_valid, cmd_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wrdata, ram_rddata, cmd_data;

  logic [DW-1:0] ram     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  word_t         sb_q[$];
  int            n_chk = 0, n_fail = 0, done_cnt = 0, werr_cnt = 0, outstanding = 0;
  bit            stall_mode = 1'b0;
  int            d0, w0;

  always #5 DfiClk = ~DfiClk;

  dwc_ddrphy_pmu_acsm_seq dut (
    .DfiClk(DfiClk), .Reset_n(Reset_n),
    .cfg_start_addr(cfg_start_addr), .cfg_stop_addr(cfg_stop_addr), .cfg_loop_cnt(cfg_loop_cnt),
    .start(start), .abort(abort), .busy(busy), .done(done), .cfg_err(cfg_err),
    .host_wr(host_wr), .host_addr(host_addr), .host_wrdata(host_wrdata), .host_wr_err(host_wr_err),
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_wr(ram_wr), .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last)
  );

  // RAM with registered address and one-cycle read latency.
  always @(posedge DfiClk) begin
    if (ram_ce && ram_wr) ram[ram_addr] <= ram_wrdata;
    if (ram_ce && !ram_wr) ram_rddata <= ram[ram_addr];
  end

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_seq(input int s, input int e, input int lp);
    for (int p = 0; p <= lp; p++)
      for (int a = s; a <= e; a++)
        sb_q.push_back({(p == lp) && (a == e), ref_mem[a]});
  endtask

  task automatic start_seq(input int s, input int e, input int lp, input bit ok);
    @(posedge DfiClk); #1;
    cfg_start_addr = AW'(s);
    cfg_stop_addr  = AW'(e);
    cfg_loop_cnt   = 16'(lp);
    start          = 1'b1;
    if (ok) push_seq(s, e, lp);
    @(posedge DfiClk); #1;
    start = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d, input bit busy_exp);
    @(posedge DfiClk); #1;
    host_wr = 1'b1; host_addr = AW'(a); host_wrdata = d;
    #1;
    if (!busy_exp) begin
      check_val("wr_pass_we", ram_wr, 1'b1);
      check_val("wr_pass_addr", ram_addr, AW'(a));
      ref_mem[a] = d;
    end else begin
      check_val("wr_blocked", ram_wr, 1'b0);
    end
    @(posedge DfiClk); #1;
    host_wr = 1'b0;
    check_val("host_wr_err", host_wr_err, busy_exp);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge DfiClk); #1;
      cmd_ready = stall_mode ? ((k % 3) == 0) : 1'b1;
      if (!busy) break;
    end
    if (k == budget) check_val("idle_timeout", 1'b1, 1'b0);
    @(posedge DfiClk); #1;
    cmd_ready = 1'b1;
  endtask

  // Monitor: scoreboard pops, stall stability, issue headroom, event counts.
  initial begin
    word_t w, prev_w;
    bit    prev_stall, pop_now, issue_now;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge DfiClk);
      if (!Reset_n) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        pop_now   = cmd_valid && cmd_ready;
        issue_now = ram_ce && !ram_wr;
        if (prev_stall) begin
          check_val("hold_valid", cmd_valid, 1'b1);
          check_val("hold_data", {cmd_last, cmd_data}, prev_w);
        end
        if (pop_now) begin
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1'b1, 1'b0);
          end else begin
            w = sb_q.pop_front();
            check_val("cmd_data", cmd_data, w[DW-1:0]);
            check_val("cmd_last", cmd_last, w[DW]);
          end
        end
        if (issue_now) check_val("issue_room", (outstanding - int'(pop_now)) < 2, 1'b1);
        if (busy && ram_ce) check_val("no_wr_busy", ram_wr, 1'b0);
        outstanding = outstanding + int'(issue_now) - int'(pop_now);
        if (done) done_cnt++;
        if (host_wr_err) werr_cnt++;
        prev_stall = cmd_valid && !cmd_ready && !abort;
        prev_w     = {cmd_last, cmd_data};
        if (abort && busy) outstanding = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge DfiClk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_valid", cmd_valid, 1'b0);
    check_val("rst_ce", ram_ce, 1'b0);
    check_val("rst_errs", {cfg_err, host_wr_err}, 2'b00);
    Reset_n = 1'b1;

    for (int i = 0; i < 16; i++) host_write(i, DW'(i), 1'b0);

    // Single pass 2..5: latency 2 cycles, 4 back-to-back words, done after last.
    d0 = done_cnt;
    start_seq(2, 5, 0, 1'b1);
    check_val("lat_c0", cmd_valid, 1'b0);
    @(posedge DfiClk); #1;
    check_val("lat_c1", cmd_valid, 1'b0);
    @(posedge DfiClk); #1;
    for (int i = 0; i < 4; i++) begin
      check_val("stream_valid", cmd_valid, 1'b1);
      @(posedge DfiClk); #1;
    end
    check_val("end_valid", cmd_valid, 1'b0);
    check_val("end_done", done, 1'b1);
    check_val("end_busy", busy, 1'b0);
    @(posedge DfiClk); #1;
    check_val("done_pulse", done, 1'b0);
    check_val("t1_done_cnt", done_cnt - d0, 1);

    // Looped 6..7 with two extra passes.
    d0 = done_cnt;
    start_seq(6, 7, 2, 1'b1);
    wait_idle(100);
    check_val("t2_done_cnt", done_cnt - d0, 1);
    check_val("t2_sb_empty", sb_q.size(), 0);

    // Backpressure pattern 1,0,0.
    d0 = done_cnt;
    stall_mode = 1'b1;
    start_seq(2, 5, 0, 1'b1);
    wait_idle(100);
    stall_mode = 1'b0;
    check_val("t3_done_cnt", done_cnt - d0, 1);
    check_val("t3_sb_empty", sb_q.size(), 0);

    // Host write while busy is dropped and flagged.
    w0 = werr_cnt;
    start_seq(0, 3, 0, 1'b1);
    host_write(2, 72'hDEAD, 1'b1);
    wait_idle(100);
    check_val("t4_werr_cnt", werr_cnt - w0, 1);
    start_seq(2, 2, 0, 1'b1);
    wait_idle(100);
    check_val("t4_sb_empty", sb_q.size(), 0);

    // Abort with one word held and one read inflight.
    d0 = done_cnt;
    cmd_ready = 1'b0;
    start_seq(0, 7, 0, 1'b1);
    @(posedge DfiClk); #1;
    @(posedge DfiClk); #1;
    check_val("ab_held", cmd_valid, 1'b1);
    abort = 1'b1;
    @(posedge DfiClk); #1;
    abort = 1'b0;
    check_val("ab_valid", cmd_valid, 1'b0);
    check_val("ab_busy", busy, 1'b0);
    check_val("ab_done", done, 1'b0);
    sb_q.delete();
    cmd_ready = 1'b1;
    @(posedge DfiClk); #1;
    check_val("ab_done2", done, 1'b0);
    check_val("ab_valid2", cmd_valid, 1'b0);
    start_seq(4, 6, 0, 1'b1);
    wait_idle(100);
    check_val("t5_done_cnt", done_cnt - d0, 1);
    check_val("t5_sb_empty", sb_q.size(), 0);

    // Rejected configuration.
    start_seq(9, 3, 0, 1'b0);
    check_val("cfg_err", cfg_err, 1'b1);
    check_val("cfg_busy", busy, 1'b0);
    @(posedge DfiClk); #1;
    check_val("cfg_err_pulse", cfg_err, 1'b0);
    check_val("cfg_busy2", busy, 1'b0);

    // Reset mid-run clears outputs asynchronously; then a normal run.
    start_seq(0, 7, 0, 1'b1);
    repeat (2) @(posedge DfiClk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_val("mr_busy", busy, 1'b0);
    check_val("mr_valid", cmd_valid, 1'b0);
    check_val("mr_ram", {ram_ce, ram_wr, ram_addr}, '0);
    check_val("mr_cmd", {cmd_last, cmd_data}, '0);
    check_val("mr_pulses", {done, cfg_err, host_wr_err}, 3'b000);
    sb_q.delete();
    @(posedge DfiClk); #1;
    Reset_n = 1'b1;
    d0 = done_cnt;
    start_seq(0, 1, 1, 1'b1);
    wait_idle(100);
    check_val("t6_done_cnt", done_cnt - d0, 1);
    check_val("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dwc_ddrphy_pmu_acsm_seq.md
Name: dwc_ddrphy_pmu_acsm_seq

Overview:
- Read sequencer that sits directly in front of the ACSM command RAM, which has a 72-bit word, a registered address and 1-cycle read latency.
- Owns the RAM address/ce/wr pins. Muxes host (PMU) writes while idle. When started, it streams RAM words from a start address to a stop address, with optional repeat loops.
- Streamed words leave on a valid/ready interface towards the ACSM command decoder.
- Absorbs RAM read latency and downstream backpressure with a 2-entry output FIFO, so throughput is one word per cycle.

Parameters:
- DATAWID, 72, RAM word width; cmd_data width.
- DEPTH, 1024, RAM entries; AW = log2(DEPTH) (10 at default).
- LOOPWID, 16, width of the loop counter.

Ports:
- DfiClk  in  1  clock
- Reset_n  in  1  asynchronous active-low reset
- cfg_start_addr  in  AW  first entry of the sequence
- cfg_stop_addr  in  AW  last entry of the sequence (inclusive)
- cfg_loop_cnt  in  LOOPWID  extra passes after the first (0 = one pass)
- start  in  1  pulse; begins a sequence when idle
- abort  in  1  pulse; terminates a sequence
- busy  out  1  sequence active
- done  out  1  1-cycle pulse at normal completion
- cfg_err  out  1  1-cycle pulse: start rejected because start_addr > stop_addr
- host_wr  in  1  host write strobe
- host_addr  in  AW  host write address
- host_wrdata  in  DATAWID  host write data
- host_wr_err  out  1  1-cycle pulse: host write dropped (busy)
- ram_addr  out  AW  RAM address
- ram_ce  out  1  RAM chip enable
- ram_wr  out  1  RAM write enable
- ram_wrdata  out  DATAWID  RAM write data
- ram_rddata  in  DATAWID  RAM read data; valid the cycle after ram_ce&!ram_wr
- cmd_valid  out  1  output word valid
- cmd_ready  in  1  downstream accepts
- cmd_data  out  DATAWID  output word
- cmd_last  out  1  final word of final pass

Behaviour:
- Reset: all registered outputs 0, state IDLE, FIFO empty, inflight=0. Reset mid-sequence discards everything, with no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - host_wr passes combinationally: ram_ce=ram_wr=1, ram_addr=host_addr, ram_wrdata=host_wrdata.
  - Otherwise ram_ce=0.
  - start with start_addr<=stop_addr loads rd_ptr=start_addr and loops=cfg_loop_cnt, then goes to RUN.
  - start with start_addr>stop_addr pulses cfg_err the next cycle and stays in IDLE.
  - start and host_wr in the same cycle: the write completes; start is taken on the same edge.
- Busy/reject rules:
  - busy=1 in RUN and DRAIN.
  - host_wr while busy: no RAM write, host_wr_err=1 the next cycle.
  - start while busy is ignored.
- RUN read issue:
  - Issue a read (ram_ce=1, ram_wr=0, ram_addr=rd_ptr) when occupancy + inflight - pop < 2, where pop = cmd_valid & cmd_ready.
  - inflight is 1 in the cycle after an issue; the returned ram_rddata is pushed into the FIFO that cycle, together with its last flag.
- Pointer advance after each issue:
  - rd_ptr != stop_addr: rd_ptr+1.
  - rd_ptr == stop_addr and loops != 0: rd_ptr = start_addr, loops - 1.
  - rd_ptr == stop_addr and loops == 0: this read is tagged last; go to DRAIN.
  - No wrap past DEPTH-1 is possible because start<=stop. Config inputs are sampled only at start.
- DRAIN: no issues. The state ends on the handshake of the last-tagged word; done=1 the cycle after that, then IDLE.
- Output side:
  - cmd_valid = FIFO non-empty; cmd_data and cmd_last come from the FIFO head.
  - Data is held stable while cmd_valid & !cmd_ready.
- Latency: start sampled at edge 0 -> read issued in cycle 0+ -> pushed at edge 2 -> cmd_valid=1 after edge 2.
  - With cmd_ready tied to 1, a sequence of N words shows cmd_valid for N consecutive cycles.
- abort (RUN/DRAIN): at the next edge the FIFO is flushed, the inflight read is dropped, the state goes to IDLE, busy=0, and done does not pulse. abort and start in the same cycle: abort wins. abort in IDLE: no effect.

Decomposition:
- Package dwc_ddrphy_pmu_acsm_pkg: state enum (IDLE/RUN/DRAIN), ACSM_DATAWID=72, ACSM_DEPTH=1024, log2 function.
- Sub-module dwc_ddrphy_pmu_acsm_seq_fifo: 2-entry FIFO of {last,data} with push/pop/flush, valid/full outputs, async active-low reset.

Test Plan:
- Host writes 0x0..0x7 to addresses 0..7 in IDLE, then start with start=2, stop=5, loop=0, ready=1 -> cmd_data 2,3,4,5 on 4 consecutive cycles starting 2 cycles after start; cmd_last on 5; done 1 cycle later.
- start=6, stop=7, loop=2 -> words 6,7,6,7,6,7; cmd_last only on the final 7; exactly one done pulse.
- Same as the first case with cmd_ready toggling 1,0,0,1,... -> no word lost or duplicated; cmd_data stable while stalled; read never issued with 2 words held.
- host_wr during RUN -> RAM content unchanged (verify by a rerun); host_wr_err pulses once.
- abort mid-stream with one word in the FIFO and a read inflight -> next cycle cmd_valid=0, busy=0, no done; a new start works normally.
- start=9, stop=3 -> cfg_err pulse, busy stays 0; Reset_n asserted mid-RUN -> all outputs 0 immediately.
